// File: rtl/dmem32_lsu.sv
// Load/store unit in front of a 32-bit word-addressed data RAM.
// It accepts one RV32I load or store at a time. It drives the word
// address, the byte-lane mask and the lane-replicated write data. For
// loads it extracts the addressed lane from the registered read word and
// sign- or zero-extends it. Each result goes out on a valid/ready response
// channel, together with the misalignment and fault flags.
module dmem32_lsu #(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_misaligned,
   output logic        resp_fault,
   output logic [29:0] mem_addr,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESP} state_t;

   localparam logic [29:0] DEPTH_W = 30'(DEPTH);

   state_t      state, state_next;
   logic [31:0] cap_addr;
   logic [2:0]  cap_funct3;

   logic        legal, misaligned, out_of_range, bad, accept;
   logic [3:0]  lane_mask;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;

   // Decode the incoming request: funct3 legality, alignment, range, lane mask.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      legal        = 1'b0;
      lane_mask    = 4'b1111;
      if (req_we)
         legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
      else
         legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                 (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
      // A reserved code has no defined width, so it is never called misaligned.
      misaligned   = legal && (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
      out_of_range = (req_addr[31:2] >= DEPTH_W);
      bad          = misaligned || !legal || out_of_range;
      case (req_funct3[1:0])
         2'b00:   lane_mask = 4'b0001 << req_addr[1:0];
         2'b01:   lane_mask = 4'b0011 << req_addr[1:0];
         default: lane_mask = 4'b1111;
      endcase
   end

   // Pick the addressed lane of the RAM word and extend it for the captured load type.
   always_comb begin
      byte_sel = mem_rdata[8*cap_addr[1:0] +: 8];
      half_sel = cap_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (cap_funct3)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_ext = {24'h0, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_ext = {16'h0, half_sel};
         default: load_ext = mem_rdata;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   // Next-state logic, the handshake outputs and the RAM-side drive.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_wmask  = 4'b0000;
      mem_addr   = cap_addr[31:2];
      mem_wdata  = req_wdata;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            mem_addr  = req_addr[31:2];
            accept    = req_valid;
            // NOTE: the mask is gated by resetn directly so a held reset can never write the unreset RAM.
            if (req_valid && req_we && !bad && resetn) mem_wmask = lane_mask;
            if (req_valid) state_next = (req_we || bad) ? RESP : LOAD_WAIT;
         end
         LOAD_WAIT: state_next = RESP;
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      case (req_funct3[1:0])
         2'b00:   mem_wdata = {4{req_wdata[7:0]}};
         2'b01:   mem_wdata = {2{req_wdata[15:0]}};
         default: mem_wdata = req_wdata;
      endcase
   end

   // Capture request fields at accept, and register the extended load result one cycle later.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cap_addr        <= 32'h0;
         cap_funct3      <= 3'b000;
         resp_rdata      <= 32'h0;
         resp_misaligned <= 1'b0;
         resp_fault      <= 1'b0;
      end else if (accept) begin
         cap_addr        <= req_addr;
         cap_funct3      <= req_funct3;
         resp_rdata      <= 32'h0;
         resp_misaligned <= misaligned;
         resp_fault      <= !legal || out_of_range;
      end else if (state == LOAD_WAIT) begin
         resp_rdata      <= load_ext;
      end
   end

endmodule

// File: tb/tb_dmem32_lsu.sv
// Self-checking bench for dmem32_lsu. It uses a behavioural RAM with a
// registered read and a byte mask. A vector table drives single operations,
// and an expected-response queue is popped as each response appears.
// Hand-written sequences cover backpressure and reset in the middle of a load.
module tb_dmem32_lsu;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_misaligned, resp_fault;
   logic [29:0] mem_addr;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata, mem_rdata;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] mwdata;
      logic [31:0] rdata;
      logic        mis;
      logic        flt;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      logic        flt;
      int          lat;
   } exp_t;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   vec_t tbl[$];
   logic [31:0] ram [64];

   dmem32_lsu #(.DEPTH(64)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
      .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: byte-masked write, registered read, not reset.
   always @(posedge clk) begin
      if (mem_addr < 30'd64) begin
         for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) ram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
         mem_rdata <= ram[mem_addr[5:0]];
      end else begin
         mem_rdata <= 32'h0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wmask,
                               input logic [31:0] mwdata, input logic [31:0] rdata,
                               input logic mis, input logic flt, input int lat);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
      v.mwdata = mwdata; v.rdata = rdata; v.mis = mis; v.flt = flt; v.lat = lat;
      return v;
   endfunction

   // Present one request, check the RAM-side drive, queue its response, and let it be accepted.
   task automatic issue(input vec_t v);
      exp_t e;
      @(negedge clk);
      req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
      #1;
      check("req_ready", 32'(req_ready), 32'd1);
      check("mem_addr", 32'(mem_addr), {2'b00, v.addr[31:2]});
      check("wmask_accept", 32'(mem_wmask), 32'(v.wmask));
      if (v.wmask != 4'b0000) check("mem_wdata", mem_wdata, v.mwdata);
      e.rdata = v.rdata; e.mis = v.mis; e.flt = v.flt; e.lat = v.lat;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("wmask_post", 32'(mem_wmask), 32'd0);
   endtask

   // Wait (bounded) for a response and compare it with the oldest expectation.
   task automatic wait_resp();
      exp_t e;
      int   lat = 1;
      while (!resp_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty: got response expected none");
      end else begin
         e = sb.pop_front();
         check("latency", 32'(lat), 32'(e.lat));
         check("resp_rdata", resp_rdata, e.rdata);
         check("resp_misaligned", 32'(resp_misaligned), 32'(e.mis));
         check("resp_fault", 32'(resp_fault), 32'(e.flt));
      end
   endtask

   // Take the response and confirm that resp_valid drops on the next cycle.
   task automatic finish_resp();
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      #1;
      check("resp_drop", 32'(resp_valid), 32'd0);
   endtask

   task automatic do_op(input vec_t v);
      issue(v);
      wait_resp();
      finish_resp();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = 32'h0;
      resp_ready = 1'b0;
      // A good store is held on the inputs during reset; it must not write the RAM.
      resetn = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h14; req_wdata = 32'hCAFE_F00D;
      #1;
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_misaligned", 32'(resp_misaligned), 32'd0);
      check("rst_fault", 32'(resp_fault), 32'd0);
      check("rst_wmask", 32'(mem_wmask), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; resetn = 1'b1;

      //            we    f3      addr        wdata         mask     mem_wdata     rdata         mis   flt   lat
      tbl.push_back(mk(1'b1, 3'b010, 32'h14,  32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1));
      tbl.push_back(mk(1'b0, 3'b010, 32'h14,  32'h0,        4'b0000, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 2));
      tbl.push_back(mk(1'b0, 3'b000, 32'h17,  32'h0,        4'b0000, 32'h0,        32'hFFFFFFDE, 1'b0, 1'b0, 2));
      tbl.push_back(mk(1'b0, 3'b100, 32'h17,  32'h0,        4'b0000, 32'h0,        32'h000000DE, 1'b0, 1'b0, 2));
      tbl.push_back(mk(1'b0, 3'b001, 32'h14,  32'h0,        4'b0000, 32'h0,        32'hFFFFBEEF, 1'b0, 1'b0, 2));
      tbl.push_back(mk(1'b0, 3'b101, 32'h16,  32'h0,        4'b0000, 32'h0,        32'h0000DEAD, 1'b0, 1'b0, 2));
      tbl.push_back(mk(1'b1, 3'b000, 32'h15,  32'hAABBCC12, 4'b0010, 32'h12121212, 32'h0,        1'b0, 1'b0, 1));
      tbl.push_back(mk(1'b0, 3'b010, 32'h14,  32'h0,        4'b0000, 32'h0,        32'hDEAD12EF, 1'b0, 1'b0, 2));
      tbl.push_back(mk(1'b1, 3'b001, 32'h16,  32'h99993456, 4'b1100, 32'h34563456, 32'h0,        1'b0, 1'b0, 1));
      tbl.push_back(mk(1'b0, 3'b010, 32'h14,  32'h0,        4'b0000, 32'h0,        32'h345612EF, 1'b0, 1'b0, 2));
      tbl.push_back(mk(1'b0, 3'b010, 32'h15,  32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1));
      tbl.push_back(mk(1'b1, 3'b001, 32'h17,  32'h0000FFFF, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 1));
      tbl.push_back(mk(1'b0, 3'b010, 32'h14,  32'h0,        4'b0000, 32'h0,        32'h345612EF, 1'b0, 1'b0, 2));
      tbl.push_back(mk(1'b0, 3'b011, 32'h0,   32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 1'b1, 1));
      tbl.push_back(mk(1'b0, 3'b010, 32'h100, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 1'b1, 1));
      tbl.push_back(mk(1'b1, 3'b100, 32'h10,  32'h55555555, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1, 1));
      tbl.push_back(mk(1'b0, 3'b010, 32'h102, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b1, 1));
      tbl.push_back(mk(1'b0, 3'b000, 32'h14,  32'h0,        4'b0000, 32'h0,        32'hFFFFFFEF, 1'b0, 1'b0, 2));
      tbl.push_back(mk(1'b0, 3'b100, 32'h15,  32'h0,        4'b0000, 32'h0,        32'h00000012, 1'b0, 1'b0, 2));
      tbl.push_back(mk(1'b0, 3'b001, 32'h16,  32'h0,        4'b0000, 32'h0,        32'h00003456, 1'b0, 1'b0, 2));
      tbl.push_back(mk(1'b1, 3'b010, 32'hFC,  32'h80000001, 4'b1111, 32'h80000001, 32'h0,        1'b0, 1'b0, 1));
      tbl.push_back(mk(1'b0, 3'b010, 32'hFC,  32'h0,        4'b0000, 32'h0,        32'h80000001, 1'b0, 1'b0, 2));
      tbl.push_back(mk(1'b0, 3'b001, 32'hFE,  32'h0,        4'b0000, 32'h0,        32'hFFFF8000, 1'b0, 1'b0, 2));

      for (int i = 0; i < tbl.size(); i++) do_op(tbl[i]);
      check("ram_word5", ram[5], 32'h345612EF);

      // Backpressure: hold the load response while a store waits at the request port.
      issue(mk(1'b0, 3'b010, 32'h14, 32'h0, 4'b0000, 32'h0, 32'h345612EF, 1'b0, 1'b0, 2));
      wait_resp();
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h11111111;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_resp_valid", 32'(resp_valid), 32'd1);
         check("bp_resp_rdata", resp_rdata, 32'h345612EF);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         check("bp_wmask", 32'(mem_wmask), 32'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      #1;
      check("bp_release_valid", 32'(resp_valid), 32'd0);
      check("bp_release_ready", 32'(req_ready), 32'd1);
      check("bp_second_wmask", 32'(mem_wmask), 32'hF);
      check("bp_second_wdata", mem_wdata, 32'h11111111);
      begin
         exp_t e;
         e.rdata = 32'h0; e.mis = 1'b0; e.flt = 1'b0; e.lat = 1;
         sb.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      wait_resp();
      finish_resp();
      do_op(mk(1'b0, 3'b010, 32'h10, 32'h0, 4'b0000, 32'h0, 32'h11111111, 1'b0, 1'b0, 2));

      // Reset during LOAD_WAIT: the pending response is dropped at once.
      issue(mk(1'b0, 3'b010, 32'h14, 32'h0, 4'b0000, 32'h0, 32'h345612EF, 1'b0, 1'b0, 2));
      void'(sb.pop_back());
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hBAD0BAD0;
      #1 resetn = 1'b0;
      #1;
      check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
      check("mid_rst_req_ready", 32'(req_ready), 32'd1);
      check("mid_rst_wmask", 32'(mem_wmask), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_wmask_hold", 32'(mem_wmask), 32'd0);
      req_valid = 1'b0;
      resetn = 1'b1;
      do_op(mk(1'b0, 3'b010, 32'h10, 32'h0, 4'b0000, 32'h0, 32'h11111111, 1'b0, 1'b0, 2));
      do_op(mk(1'b0, 3'b010, 32'h14, 32'h0, 4'b0000, 32'h0, 32'h345612EF, 1'b0, 1'b0, 2));

      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
